// File: rtl/wr_sel_pkg.sv
// rtl/wr_sel_pkg.sv - shared types and helpers for the write-select encoder
package wr_sel_pkg;

    localparam int N_DEFAULT = 4;
    localparam int W_DEFAULT = $clog2(N_DEFAULT);

    typedef logic [W_DEFAULT-1:0] idx_t;

    // Index of the lowest set bit; for a one-hot vector this is its binary encoding.
    function automatic int onehot_to_bin(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/wr_sel_encoder_rr_pick.sv
// rtl/wr_sel_encoder_rr_pick.sv - rotating priority picker (rotate, encode, un-rotate)
module rr_pick
    import wr_sel_pkg::*;
#(
    parameter  int N = N_DEFAULT,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] sel,
    output logic         any
);

    logic [N-1:0] rot;
    logic [W-1:0] pos;

    // N is a power of two, so W-bit index arithmetic wraps modulo N for free.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[W'(i) + ptr];
        end
    end

    always_comb begin
        pos = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) pos = W'(i);
        end
    end

    assign sel = pos + ptr;
    assign any = |req;

endmodule

// File: rtl/wr_sel_encoder.sv
// rtl/wr_sel_encoder.sv - one-hot write requests to registered index; WR_SEL_RR_EN selects round-robin
module wr_sel_encoder
    import wr_sel_pkg::*;
#(
    parameter  int N = N_DEFAULT,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] grant,
    output logic         busy
);

    logic [W-1:0] ptr;
    logic [W-1:0] sel;
    logic         any;
    logic         load;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q, out_idx_d;

    rr_pick #(.N(N)) u_pick (
        .req (req),
        .ptr (ptr),
        .sel (sel),
        .any (any)
    );

    assign load  = any & (~out_valid_q | out_ready) & ~reset;
    assign grant = load ? (N'(1) << sel) : '0;
    assign busy  = out_valid_q | any;

`ifdef WR_SEL_RR_EN
    logic [W-1:0] rr_ptr_q, rr_ptr_d;

    assign rr_ptr_d = load ? (sel + W'(1)) : rr_ptr_q;
    assign ptr      = rr_ptr_q;

    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
`else
    assign ptr = '0;
`endif

    // Accept and reload in the same cycle keeps out_valid high with no bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_idx_d   = sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;

endmodule
